// File: rtl/arc4_phase_ctrl.sv
// -----------------------------------------------------------------------------
// arc4_phase_ctrl
//   Top-level sequencer for the ARC4 decrypter. A single accepted start
//   request runs three sub-blocks in a fixed order: init (S[i]=i), then ksa,
//   then prga. The controller owns the single-port S memory and routes that
//   port to whichever sub-block is in its phase. Each phase has a watchdog.
//   A write attempt by a client that does not own the memory raises a sticky
//   error flag.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   en / rdy              start request / controller idle (en honoured only
//                         while rdy=1)
//   phase                 0=idle 1=init 2=ksa 3=prga
//   err                   sticky error (protocol violation or watchdog),
//                         cleared by reset or by an accepted en
//   init_en/ksa_en/prga_en       one-cycle start pulse to each sub-block
//   init_rdy/ksa_rdy/prga_rdy    sub-block idle
//   <client>_addr/_wrdata/_wren  client memory requests
//   s_addr/s_wrdata/s_wren       muxed S-memory port
// -----------------------------------------------------------------------------
module arc4_phase_ctrl #(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [1:0]        phase,
  output logic              err,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_START,
    S_INIT_WAIT,
    S_KSA_START,
    S_KSA_WAIT,
    S_PRGA_START,
    S_PRGA_WAIT
  } state_t;

  // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES < 1) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_seen_low;
  logic [WD_W-1:0]   r_wd_cnt;
  logic              r_err;

  logic              w_in_wait;
  logic              w_cur_rdy;
  logic              w_done;
  logic              w_timeout;
  logic              w_accept;
  logic              w_wait_entry;
  logic              w_own_init;
  logic              w_own_ksa;
  logic              w_own_prga;
  logic              w_proto;

  // Which sub-block the current WAIT state is watching.
  always_comb begin
    w_in_wait = 1'b0;
    w_cur_rdy = 1'b0;
    case (r_state)
      S_INIT_WAIT: begin w_in_wait = 1'b1; w_cur_rdy = init_rdy; end
      S_KSA_WAIT:  begin w_in_wait = 1'b1; w_cur_rdy = ksa_rdy;  end
      S_PRGA_WAIT: begin w_in_wait = 1'b1; w_cur_rdy = prga_rdy; end
      default:     begin w_in_wait = 1'b0; w_cur_rdy = 1'b0;     end
    endcase
  end

  // A sub-block that is still showing rdy=1 right after its en has not
  // started yet; only a rising rdy after a low one means it finished.
  assign w_done    = w_in_wait && w_cur_rdy && r_seen_low;
  // Completion in the same cycle as expiry wins.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_in_wait && !w_done &&
                     (r_wd_cnt == WD_LAST);
  assign w_accept  = (r_state == S_IDLE) && en;
  // The en pulse is exactly the START->WAIT transition.
  assign w_wait_entry = init_en | ksa_en | prga_en;

  assign w_proto = (init_wren & ~w_own_init) |
                   (ksa_wren  & ~w_own_ksa)  |
                   (prga_wren & ~w_own_prga);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (en) w_next = S_INIT_START;
      S_INIT_START: if (init_rdy) w_next = S_INIT_WAIT;
      S_INIT_WAIT: begin
        if (w_done)         w_next = S_KSA_START;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_KSA_START:  if (ksa_rdy) w_next = S_KSA_WAIT;
      S_KSA_WAIT: begin
        if (w_done)         w_next = S_PRGA_START;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_PRGA_START: if (prga_rdy) w_next = S_PRGA_WAIT;
      S_PRGA_WAIT: begin
        if (w_done || w_timeout) w_next = S_IDLE;
      end
      default:      w_next = S_IDLE;
    endcase
  end

  // Outputs and memory mux, all decoded from the current state
  always_comb begin
    rdy        = 1'b0;
    phase      = 2'd0;
    init_en    = 1'b0;
    ksa_en     = 1'b0;
    prga_en    = 1'b0;
    s_addr     = '0;
    s_wrdata   = '0;
    s_wren     = 1'b0;
    w_own_init = 1'b0;
    w_own_ksa  = 1'b0;
    w_own_prga = 1'b0;
    case (r_state)
      S_IDLE: rdy = 1'b1;
      S_INIT_START, S_INIT_WAIT: begin
        phase      = 2'd1;
        w_own_init = 1'b1;
        init_en    = (r_state == S_INIT_START) && init_rdy;
        s_addr     = init_addr;
        s_wrdata   = init_wrdata;
        s_wren     = init_wren;
      end
      S_KSA_START, S_KSA_WAIT: begin
        phase      = 2'd2;
        w_own_ksa  = 1'b1;
        ksa_en     = (r_state == S_KSA_START) && ksa_rdy;
        s_addr     = ksa_addr;
        s_wrdata   = ksa_wrdata;
        s_wren     = ksa_wren;
      end
      S_PRGA_START, S_PRGA_WAIT: begin
        phase      = 2'd3;
        w_own_prga = 1'b1;
        prga_en    = (r_state == S_PRGA_START) && prga_rdy;
        s_addr     = prga_addr;
        s_wrdata   = prga_wrdata;
        s_wren     = prga_wren;
      end
      default: rdy = 1'b0;
    endcase
  end

  // Completion tracking, watchdog and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_low <= 1'b0;
      r_wd_cnt   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_wait_entry) begin
        r_seen_low <= 1'b0;
        r_wd_cnt   <= '0;
      end else if (w_in_wait) begin
        r_seen_low <= r_seen_low | ~w_cur_rdy;
        r_wd_cnt   <= r_wd_cnt + WD_W'(1);
      end
      // A violation in the accepting cycle itself still registers.
      r_err <= (w_accept ? 1'b0 : r_err) | w_proto | w_timeout;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_arc4_phase_ctrl.sv
module tb_arc4_phase_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en, rdy, err;
  logic [1:0] phase;
  logic       init_en, ksa_en, prga_en;
  logic       init_rdy, ksa_rdy, prga_rdy;
  logic [7:0] init_addr, ksa_addr, prga_addr;
  logic [7:0] init_wrdata, ksa_wrdata, prga_wrdata;
  logic       init_wren, ksa_wren, prga_wren;
  logic [7:0] s_addr, s_wrdata;
  logic       s_wren;

  // second instance with a short watchdog
  logic       wd_en, wd_rdy, wd_err;
  logic [1:0] wd_phase;
  logic       wd_init_en, wd_ksa_en, wd_prga_en;
  logic       wd_init_rdy, wd_ksa_rdy, wd_prga_rdy;
  logic [7:0] wd_s_addr, wd_s_wrdata;
  logic       wd_s_wren;
  logic [7:0] zero8 = 8'h00;
  logic       zero1 = 1'b0;

  arc4_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .phase(phase), .err(err),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  arc4_phase_ctrl #(.TIMEOUT_CYCLES(16)) dut_wd (
    .clk(clk), .rst_n(rst_n), .en(wd_en), .rdy(wd_rdy), .phase(wd_phase), .err(wd_err),
    .init_en(wd_init_en), .ksa_en(wd_ksa_en), .prga_en(wd_prga_en),
    .init_rdy(wd_init_rdy), .ksa_rdy(wd_ksa_rdy), .prga_rdy(wd_prga_rdy),
    .init_addr(zero8), .ksa_addr(zero8), .prga_addr(zero8),
    .init_wrdata(zero8), .ksa_wrdata(zero8), .prga_wrdata(zero8),
    .init_wren(zero1), .ksa_wren(zero1), .prga_wren(zero1),
    .s_addr(wd_s_addr), .s_wrdata(wd_s_wrdata), .s_wren(wd_s_wren)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- table vectors ----------------
  // bit order in the 3-bit fields: {init, ksa, prga}
  typedef struct packed {
    logic       en;
    logic [2:0] rdys;
    logic [2:0] wrens;
    logic       exp_rdy;
    logic [1:0] exp_ph;
    logic [2:0] exp_en;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_swren;
    logic       exp_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  // ---------------- mock sub-blocks ----------------
  // t = cycles since the mock's en (0 = idle). rdy stays high for L cycles
  // after en, is low for B cycles, then returns high.
  int t_i, t_k, t_p, L_i, B_i, L_k, B_k, L_p, B_p;
  int n_init, n_ksa, n_prga, c_init, c_ksa, c_prga, cyc;
  int rdy_bad, err_seen;
  logic [1:0]  last_phase;
  logic [31:0] ph_code;

  function automatic logic mock_rdy(input int t, input int L, input int B);
    if (t == 0)     return 1'b1;
    if (t <= L)     return 1'b1;
    if (t <= L + B) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mock_reset();
    t_i = 0; t_k = 0; t_p = 0;
    n_init = 0; n_ksa = 0; n_prga = 0;
    c_init = 0; c_ksa = 0; c_prga = 0; cyc = 0;
    rdy_bad = 0; err_seen = 0;
    last_phase = 2'd0; ph_code = 32'h0;
  endtask

  task automatic step(input logic en_v);
    @(negedge clk);
    en       = en_v;
    init_rdy = mock_rdy(t_i, L_i, B_i);
    ksa_rdy  = mock_rdy(t_k, L_k, B_k);
    prga_rdy = mock_rdy(t_p, L_p, B_p);
    #1;
    cyc++;
    if (init_en) begin n_init++; c_init = cyc; t_i = 1; end else if (t_i > 0) t_i++;
    if (ksa_en)  begin n_ksa++;  c_ksa  = cyc; t_k = 1; end else if (t_k > 0) t_k++;
    if (prga_en) begin n_prga++; c_prga = cyc; t_p = 1; end else if (t_p > 0) t_p++;
    if (err) err_seen++;
    if (rdy !== (phase == 2'd0)) rdy_bad++;
    if (phase != last_phase) begin
      ph_code = (ph_code << 4) | {30'd0, phase};
      last_phase = phase;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; init_rdy = 1'b1; ksa_rdy = 1'b1; prga_rdy = 1'b1;
    init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
    wd_en = 1'b0; wd_init_rdy = 1'b1; wd_ksa_rdy = 1'b1; wd_prga_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int c_done, wait_n, bad, i;
    logic done;

    init_addr = 8'h11; init_wrdata = 8'h22;
    ksa_addr  = 8'h2A; ksa_wrdata  = 8'h55;
    prga_addr = 8'h33; prga_wrdata = 8'h44;
    L_i = 0; B_i = 0; L_k = 0; B_k = 0; L_p = 0; B_p = 0;
    mock_reset();

    //           en  rdys    wrens   rdy ph    ens     addr   data   sw    err
    tbl[0]  = '{1'b0, 3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 3'b011, 3'b000, 1'b0, 2'd1, 3'b000, 8'h11, 8'h22, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'b111, 3'b000, 1'b0, 2'd1, 3'b100, 8'h11, 8'h22, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 3'b111, 3'b000, 1'b0, 2'd1, 3'b000, 8'h11, 8'h22, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'b011, 3'b100, 1'b0, 2'd1, 3'b000, 8'h11, 8'h22, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 3'b111, 3'b000, 1'b0, 2'd1, 3'b000, 8'h11, 8'h22, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3'b111, 3'b000, 1'b0, 2'd2, 3'b010, 8'h2A, 8'h55, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 3'b101, 3'b010, 1'b0, 2'd2, 3'b000, 8'h2A, 8'h55, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 3'b101, 3'b110, 1'b0, 2'd2, 3'b000, 8'h2A, 8'h55, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 3'b111, 3'b000, 1'b0, 2'd2, 3'b000, 8'h2A, 8'h55, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 3'b111, 3'b000, 1'b0, 2'd3, 3'b001, 8'h33, 8'h44, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 3'b110, 3'b000, 1'b0, 2'd3, 3'b000, 8'h33, 8'h44, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'b111, 3'b001, 1'b0, 2'd3, 3'b000, 8'h33, 8'h44, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 3'b111, 3'b000, 1'b0, 2'd1, 3'b100, 8'h11, 8'h22, 1'b0, 1'b0};

    // ---- table: handshake, mux, protocol error, sticky err ----
    do_reset();
    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      en = tbl[v].en;
      {init_rdy, ksa_rdy, prga_rdy}    = tbl[v].rdys;
      {init_wren, ksa_wren, prga_wren} = tbl[v].wrens;
      #1;
      check($sformatf("v%0d_rdy", v),    {31'd0, rdy},    {31'd0, tbl[v].exp_rdy});
      check($sformatf("v%0d_phase", v),  {30'd0, phase},  {30'd0, tbl[v].exp_ph});
      check($sformatf("v%0d_en", v),     {29'd0, init_en, ksa_en, prga_en}, {29'd0, tbl[v].exp_en});
      check($sformatf("v%0d_saddr", v),  {24'd0, s_addr}, {24'd0, tbl[v].exp_addr});
      check($sformatf("v%0d_swdata", v), {24'd0, s_wrdata}, {24'd0, tbl[v].exp_data});
      check($sformatf("v%0d_swren", v),  {31'd0, s_wren}, {31'd0, tbl[v].exp_swren});
      check($sformatf("v%0d_err", v),    {31'd0, err},    {31'd0, tbl[v].exp_err});
    end
    init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;

    // ---- happy path with mocks (busy 256/768/32) ----
    do_reset();
    mock_reset();
    L_i = 0; B_i = 256; L_k = 0; B_k = 768; L_p = 0; B_p = 32;
    step(1'b1);
    done = 1'b0;
    for (i = 0; i < 3000 && !done; i++) begin
      step(1'b0);
      if (phase == 2'd0 && n_prga == 1) done = 1'b1;
    end
    c_done = cyc;
    check("happy_done", {31'd0, done}, 32'd1);
    check("happy_counts", {n_init[7:0], n_ksa[7:0], n_prga[7:0]}, 24'h010101);
    check("happy_init_lat", c_init, 2);
    check("happy_ksa_after_init", c_ksa - c_init, 258);
    check("happy_prga_after_ksa", c_prga - c_ksa, 770);
    check("happy_idle_after_prga", c_done - c_prga, 34);
    check("happy_phase_seq", ph_code, 32'h1230);
    check("happy_rdy_consistent", rdy_bad, 0);
    check("happy_err_clear", err_seen, 0);

    // ---- slow init rdy, plus en hammered during prga ----
    mock_reset();
    L_i = 2; B_i = 5; L_k = 0; B_k = 4; L_p = 0; B_p = 4;
    step(1'b1);
    done = 1'b0;
    for (i = 0; i < 200 && !done; i++) begin
      step(t_p >= 1 && t_p <= L_p + B_p + 1);
      if (phase == 2'd0 && n_prga == 1) done = 1'b1;
    end
    repeat (5) step(1'b0);
    check("slow_done", {31'd0, done}, 32'd1);
    check("slow_ksa_after_init", c_ksa - c_init, 9);
    check("slow_prga_after_ksa", c_prga - c_ksa, 6);
    check("busy_single_init_en", n_init, 1);
    check("busy_phase_seq", ph_code, 32'h1230);
    check("busy_final_rdy", {31'd0, rdy}, 32'd1);
    check("slow_err_clear", err_seen, 0);

    // ---- watchdog (TIMEOUT_CYCLES=16, ksa never returns) ----
    @(negedge clk); wd_en = 1'b1; #1;
    check("wd_idle_rdy", {31'd0, wd_rdy}, 32'd1);
    @(negedge clk); wd_en = 1'b0; wd_init_rdy = 1'b1; #1;
    check("wd_init_en", {31'd0, wd_init_en}, 32'd1);
    @(negedge clk); wd_init_rdy = 1'b0;
    @(negedge clk); wd_init_rdy = 1'b1; #1;
    check("wd_init_phase", {30'd0, wd_phase}, 32'd1);
    @(negedge clk); #1;
    check("wd_ksa_en", {31'd0, wd_ksa_en}, 32'd1);
    wait_n = 0; bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); wd_ksa_rdy = 1'b0; #1;
      if (wd_phase == 2'd2 && !wd_rdy) wait_n++;
      if (wd_prga_en) bad++;
    end
    check("wd_wait_cycles", wait_n, 16);
    check("wd_err_not_early", {31'd0, wd_err}, 32'd0);
    @(negedge clk); #1;
    check("wd_timeout_state", {29'd0, wd_rdy, wd_phase}, {29'd0, 1'b1, 2'd0});
    check("wd_timeout_err", {31'd0, wd_err}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (wd_prga_en || wd_phase != 2'd0 || wd_ksa_en || wd_init_en) bad++;
    end
    check("wd_no_further_phase", bad, 0);

    // ---- reset mid-KSA ----
    mock_reset();
    L_i = 0; B_i = 3; L_k = 0; B_k = 50; L_p = 0; B_p = 4;
    step(1'b1);
    done = 1'b0;
    for (i = 0; i < 50 && !done; i++) begin
      step(1'b0);
      if (phase == 2'd2) done = 1'b1;
    end
    check("rst_reached_ksa", {31'd0, done}, 32'd1);
    repeat (3) step(1'b0);
    ksa_wren = 1'b1;
    #1;
    check("rst_pre_swren", {31'd0, s_wren}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_rdy_phase", {29'd0, rdy, phase}, {29'd0, 1'b1, 2'd0});
    check("rst_async_ens", {29'd0, init_en, ksa_en, prga_en}, 32'd0);
    check("rst_async_swren", {31'd0, s_wren}, 32'd0);
    ksa_wren = 1'b0;
    @(negedge clk); #3;
    rst_n = 1'b1;
    mock_reset();
    repeat (10) step(1'b0);
    check("rst_no_en_after_release", n_init + n_ksa + n_prga, 0);
    check("rst_idle_after_release", {29'd0, rdy, phase}, {29'd0, 1'b1, 2'd0});
    check("rst_err_clear", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
